// File: rtl/game_timer_pkg.sv
// Shared constants and helpers for the game time base.
package game_timer_pkg;

  localparam int unsigned TIME_W = 20;
  localparam logic [TIME_W-1:0] TIME_WRAP = 20'd999_999;

  // Clock cycles per tick; the caller guarantees an exact integer ratio >= 2.
  function automatic int unsigned div_of(input int unsigned clk_hz,
                                         input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/tick_timer_scheduler_arbiter.sv
// Round-robin arbiter: one-hot grant over unmasked requests, search starting
// one past the last granted channel.
module rr_arbiter
  import game_timer_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] mask_i,
  input  logic         advance_i,
  output logic [N-1:0] gnt_c
);

  localparam int unsigned PW = $clog2(N);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  elig_c;
  logic [PW:0]   idx_w;
  logic [PW-1:0] idx;
  logic          found;

  assign elig_c = req_i & ~mask_i;

  // First eligible channel at or after the pointer, wrapping modulo N.
  always_comb begin
    gnt_c = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx_w = '0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx_w = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx_w >= (PW+1)'(N)) idx_w = idx_w - (PW+1)'(N);
      idx = PW'(idx_w);
      if (!found && elig_c[idx]) begin
        found      = 1'b1;
        gnt_c[idx] = 1'b1;
        ptr_d      = (idx == PW'(N-1)) ? '0 : idx + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/tick_timer_scheduler.sv
// 100 Hz time base with free-running centisecond count and NUM_CH one-shot
// countdown channels armed through a round-robin req/ack handshake.
module tick_timer_scheduler
  import game_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_HZ = 100,
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned DUR_W   = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    pause,
  input  logic [NUM_CH-1:0]       arm_req,
  input  logic [NUM_CH*DUR_W-1:0] arm_dur,
  output logic [NUM_CH-1:0]       arm_ack,
  input  logic [NUM_CH-1:0]       cancel,
  output logic                    tick,
  output logic [TIME_W-1:0]       time_cs,
  output logic [NUM_CH-1:0]       active,
  output logic [NUM_CH-1:0]       expire
);

  localparam int unsigned DIV = div_of(CLK_HZ, TICK_HZ);
  localparam int unsigned PW  = $clog2(DIV);

  logic [PW-1:0]     presc_q, presc_d;
  logic              tick_q;
  logic [TIME_W-1:0] time_q, time_d;
  logic [NUM_CH-1:0] ack_q, active_q, active_d, expire_q, expire_d;
  logic [DUR_W-1:0]  rem_q [NUM_CH];
  logic [DUR_W-1:0]  rem_d [NUM_CH];
  logic [NUM_CH-1:0] gnt_c;
  logic              tick_evt_c;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_i     (arm_req),
    .mask_i    (cancel),
    .advance_i (|gnt_c),
    .gnt_c     (gnt_c)
  );

  // Prescaler wrap is the tick event; it drives time_cs and countdowns on the same edge.
  assign tick_evt_c = !pause && (presc_q == PW'(DIV-1));

  always_comb begin
    presc_d = presc_q;
    time_d  = time_q;
    if (!pause) presc_d = tick_evt_c ? '0 : presc_q + PW'(1);
    if (tick_evt_c) time_d = (time_q == TIME_WRAP) ? '0 : time_q + TIME_W'(1);
  end

  // Per-channel priority: cancel, then reload on grant, then tick decrement.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      rem_d[c]    = rem_q[c];
      expire_d[c] = 1'b0;
      if (cancel[c]) begin
        rem_d[c] = '0;
      end else if (gnt_c[c]) begin
        rem_d[c]    = arm_dur[c*DUR_W +: DUR_W];
        expire_d[c] = (arm_dur[c*DUR_W +: DUR_W] == '0);
      end else if (tick_evt_c && (rem_q[c] != '0)) begin
        rem_d[c]    = rem_q[c] - DUR_W'(1);
        expire_d[c] = (rem_q[c] == DUR_W'(1));
      end
      active_d[c] = (rem_d[c] != '0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q  <= '0;
      tick_q   <= 1'b0;
      time_q   <= '0;
      ack_q    <= '0;
      active_q <= '0;
      expire_q <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) rem_q[c] <= '0;
    end else begin
      presc_q  <= presc_d;
      tick_q   <= tick_evt_c;
      time_q   <= time_d;
      ack_q    <= gnt_c;
      active_q <= active_d;
      expire_q <= expire_d;
      for (int unsigned c = 0; c < NUM_CH; c++) rem_q[c] <= rem_d[c];
    end
  end

  assign tick    = tick_q;
  assign time_cs = time_q;
  assign arm_ack = ack_q;
  assign active  = active_q;
  assign expire  = expire_q;

endmodule

// File: tb/tb_tick_timer_scheduler.sv
// Scoreboard bench: a tick/deadline reference model queues expected events,
// a negedge monitor pops and compares them against the scheduler outputs.
module tb_tick_timer_scheduler;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int NUM_CH  = 4;
  localparam int DUR_W   = 16;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam logic [NUM_CH-1:0] ONE = 1;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic                    pause = 1'b0;
  logic [NUM_CH-1:0]       arm_req = '0;
  logic [NUM_CH*DUR_W-1:0] arm_dur = '0;
  logic [NUM_CH-1:0]       cancel = '0;
  logic [NUM_CH-1:0]       arm_ack, active, expire;
  logic                    tick;
  logic [19:0]             time_cs;

  tick_timer_scheduler #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NUM_CH(NUM_CH), .DUR_W(DUR_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pause(pause),
    .arm_req(arm_req), .arm_dur(arm_dur), .arm_ack(arm_ack),
    .cancel(cancel), .tick(tick), .time_cs(time_cs),
    .active(active), .expire(expire)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int ch; } ev_t;
  ev_t ack_q[$];
  ev_t exp_q[$];
  int  tick_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: ticks come from counting unpaused cycles,
  // channels are remaining-tick counts, arbitration is a rotated search.
  int cyc = 0;
  int m_run, m_time, m_last;
  int m_rem [NUM_CH];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic m_reset();
    m_run  = 0;
    m_time = 0;
    m_last = NUM_CH - 1;
    for (int c = 0; c < NUM_CH; c++) m_rem[c] = 0;
  endtask

  task automatic m_step();
    bit tick_now;
    int win, c, dur;
    cyc++;
    tick_now = 1'b0;
    if (!pause) begin
      m_run++;
      tick_now = (m_run % DIV == 0);
    end
    if (tick_now) begin
      m_time = (m_time + 1) % 1000000;
      tick_q.push_back(cyc);
    end
    win = -1;
    for (int k = 1; k <= NUM_CH; k++) begin
      c = (m_last + k) % NUM_CH;
      if (win < 0 && arm_req[c] && !cancel[c]) win = c;
    end
    if (win >= 0) begin
      m_last = win;
      ack_q.push_back('{cyc, win});
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      dur = int'(arm_dur[ch*DUR_W +: DUR_W]);
      if (cancel[ch]) m_rem[ch] = 0;
      else if (ch == win) begin
        m_rem[ch] = dur;
        if (dur == 0) exp_q.push_back('{cyc, ch});
      end else if (tick_now && m_rem[ch] > 0) begin
        m_rem[ch]--;
        if (m_rem[ch] == 0) exp_q.push_back('{cyc, ch});
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) m_reset();
      else m_step();
    end
  end

  // Monitor: pop everything the model expects for this cycle and compare.
  initial begin
    logic [NUM_CH-1:0] ea, ee, ma;
    logic et;
    ev_t ev;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        ea = '0; ee = '0; et = 1'b0; ma = '0;
        while (ack_q.size() > 0 && ack_q[0].cyc <= cyc) begin
          ev = ack_q.pop_front();
          ea = ea | (ONE << ev.ch);
        end
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          ev = exp_q.pop_front();
          ee = ee | (ONE << ev.ch);
        end
        while (tick_q.size() > 0 && tick_q[0] <= cyc) begin
          void'(tick_q.pop_front());
          et = 1'b1;
        end
        for (int c = 0; c < NUM_CH; c++) if (m_rem[c] != 0) ma = ma | (ONE << c);
        if (ea != 0 || arm_ack != 0) chk("arm_ack", 64'(arm_ack), 64'(ea));
        if (ee != 0 || expire != 0)  chk("expire", 64'(expire), 64'(ee));
        if (et || tick)              chk("tick", 64'(tick), 64'(et));
        chk("time_cs", 64'(time_cs), 64'(m_time));
        chk("active", 64'(active), 64'(ma));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
    cancel = '0;
    for (int c = 0; c < NUM_CH; c++) if (arm_ack[c]) arm_req[c] = 1'b0;
  endtask

  task automatic set_dur(input int c, input int d);
    arm_dur[c*DUR_W +: DUR_W] = DUR_W'(d);
  endtask

  task automatic arm(input int c, input int d);
    int n;
    arm_req[c] = 1'b1;
    set_dur(c, d);
    n = 0;
    while (arm_req[c] && n < 3 * NUM_CH) begin
      step();
      n++;
    end
    chk("ack_wait", 64'(arm_req[c]), 64'(0));
  endtask

  function automatic int oh_idx(input logic [NUM_CH-1:0] v);
    int r = -1;
    for (int i = 0; i < NUM_CH; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    int n, nt;
    int order_a [NUM_CH];
    int order_b [NUM_CH];
    order_a = '{0, 1, 2, 3};
    order_b = '{2, 3, 0, 1};

    // Reset state, then 35 cycles of free-running time base.
    step(); step();
    chk("reset_state", 64'({time_cs, tick, arm_ack, active, expire}), 64'(0));
    reset_n = 1'b1;
    repeat (35) step();
    chk("time_cs_after_35", 64'(time_cs), 64'(3));

    // Wrap boundary 999_999 -> 0 on the next tick (cycle 40).
    step();
    force dut.time_q = 20'd999_999;
    m_time = 999999;
    step();
    release dut.time_q;
    repeat (3) step();
    chk("time_wrap", 64'(time_cs), 64'(0));
    chk("tick_at_wrap", 64'(tick), 64'(1));

    // Uncontended arm of ch1 for 3 ticks.
    arm(1, 3);
    chk("ch1_active", 64'(active[1]), 64'(1));
    repeat (40) step();

    // Round-robin waves: pointer at ch0, then after a lone grant on ch1.
    arm(3, 2);
    for (int c = 0; c < NUM_CH; c++) set_dur(c, 40 + c);
    arm_req = '1;
    for (int k = 0; k < NUM_CH; k++) begin
      step();
      chk("wave1_order", 64'(oh_idx(arm_ack)), 64'(order_a[k]));
    end
    arm(1, 7);
    for (int c = 0; c < NUM_CH; c++) set_dur(c, 20 + c);
    arm_req = '1;
    for (int k = 0; k < NUM_CH; k++) begin
      step();
      chk("wave2_order", 64'(oh_idx(arm_ack)), 64'(order_b[k]));
    end

    // Cancel mid-countdown, then cancel colliding with a new request.
    arm(2, 5);
    nt = 0; n = 0;
    while (nt < 2 && n < 100) begin
      step();
      if (tick) nt++;
      n++;
    end
    chk("two_ticks_seen", 64'(nt), 64'(2));
    cancel[2] = 1'b1;
    step();
    chk("cancel_clears", 64'(active[2]), 64'(0));
    arm_req[2] = 1'b1;
    set_dur(2, 6);
    cancel[2] = 1'b1;
    step();
    chk("cancel_defers_ack", 64'(arm_ack[2]), 64'(0));
    step();
    chk("deferred_ack", 64'(arm_ack[2]), 64'(1));
    repeat (80) step();

    // Zero duration expires on the ack edge; reload on the expiry tick.
    arm(3, 0);
    chk("dur0_expire", 64'(expire[3]), 64'(1));
    chk("dur0_inactive", 64'(active[3]), 64'(0));
    arm(0, 2);
    n = 0;
    while (!(m_rem[0] == 1 && (m_run % DIV) == DIV - 1) && n < 200) begin
      step();
      n++;
    end
    chk("rearm_slot_found", 64'(m_rem[0]), 64'(1));
    arm_req[0] = 1'b1;
    set_dur(0, 4);
    step();
    chk("rearm_ack", 64'(arm_ack[0]), 64'(1));
    chk("rearm_no_expire", 64'(expire[0]), 64'(0));
    chk("rearm_active", 64'(active[0]), 64'(1));
    repeat (50) step();

    // Pause freezes everything mid-countdown.
    arm(1, 10);
    repeat (15) step();
    pause = 1'b1;
    repeat (50) step();
    pause = 1'b0;
    repeat (120) step();

    // Reset mid-count with requests pending across it.
    arm(0, 9);
    repeat (12) step();
    set_dur(1, 3);
    set_dur(2, 4);
    arm_req[1] = 1'b1;
    arm_req[2] = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("reset_mid_count", 64'({time_cs, tick, arm_ack, active, expire}), 64'(0));
    step();
    reset_n = 1'b1;
    step();
    chk("post_reset_first", 64'(oh_idx(arm_ack)), 64'(1));
    step();
    chk("post_reset_second", 64'(oh_idx(arm_ack)), 64'(2));
    repeat (60) step();

    // Randomized traffic with held requests, cancels and pause bursts.
    repeat (3000) begin
      step();
      if ($urandom_range(0, 63) == 0) pause = ~pause;
      for (int c = 0; c < NUM_CH; c++) begin
        if (!arm_req[c] && $urandom_range(0, 9) == 0) begin
          arm_req[c] = 1'b1;
          set_dur(c, int'($urandom_range(0, 30)));
        end
        if ($urandom_range(0, 49) == 0) cancel[c] = 1'b1;
      end
    end
    pause = 1'b0;
    arm_req = '0;
    repeat (5) step();
    @(negedge clk);
    #1;
    chk("queues_drained", 64'(ack_q.size() + exp_q.size() + tick_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
